// File: rtl/multimode_shift_counter.sv
// multimode_shift_counter
//   Johnson (twisted ring) or ring (one-hot) shift counter with direction
//   control, synchronous parallel load and optional illegal-state recovery.
//
//   Build option: define SHIFT_CNT_SELF_CORRECT_EN to enable the combinational
//   legality check (illegal flag) and automatic return to HOME from any state
//   that is illegal for the current mode. Undefined: illegal is tied to 0 and
//   every state simply shifts.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-high reset, forces q to HOME
//   en       : count enable
//   dir      : 1 = shift left (up), 0 = shift right (down)
//   mode     : 0 = Johnson, 1 = ring
//   load     : synchronous load strobe, highest priority after reset
//   load_val : value captured on load (need not be legal)
//   q        : registered counter state
//   tc       : combinational, 1 when the next enabled shift lands on HOME
//   illegal  : combinational, q is not a legal state for the current mode

module multimode_shift_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] HOME = WIDTH'(1);

    logic [WIDTH-1:0] shift_next;
    logic             legal;
    logic             recover;

    always_comb begin
        shift_next = q;
        unique case ({mode, dir})
            2'b01:   shift_next = {q[WIDTH-2:0], ~q[WIDTH-1]};  // Johnson up
            2'b00:   shift_next = {~q[0], q[WIDTH-1:1]};        // Johnson down
            2'b11:   shift_next = {q[WIDTH-2:0], q[WIDTH-1]};   // ring up
            2'b10:   shift_next = {q[0], q[WIDTH-1:1]};         // ring down
            default: shift_next = q;
        endcase
    end

`ifdef SHIFT_CNT_SELF_CORRECT_EN
    // Johnson states have at most one boundary between adjacent differing bits.
    logic [WIDTH-2:0] bit_edges;
    logic             johnson_ok;
    logic             ring_ok;

    assign bit_edges  = q[WIDTH-2:0] ^ q[WIDTH-1:1];
    assign johnson_ok = (bit_edges & (bit_edges - (WIDTH-1)'(1))) == '0;
    assign ring_ok    = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
    assign legal      = mode ? ring_ok : johnson_ok;
    assign recover    = ~legal;
    assign illegal    = ~legal;
`else
    assign legal      = 1'b1;
    assign recover    = 1'b0;
    assign illegal    = 1'b0;
`endif

    assign tc = ~rst & en & ~load & legal & (shift_next == HOME);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= HOME;
        end else if (load) begin
            q <= load_val;
        end else if (recover) begin
            q <= HOME;
        end else if (en) begin
            q <= shift_next;
        end
    end

endmodule
